// File: rtl/data_memory_responder.sv
// data_memory_responder
// Multicycle data-memory slave for a processor memory stage. Accepts one
// load/store at a time and waits LATENCY cycles. It then commits stores with a
// byte-lane read-modify-write, or returns the load field extended per size and
// signedness. Misaligned or out-of-range accesses return resp_err with zero
// data and leave the array untouched.
module data_memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  // Word-index width and latency-counter width
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  // Access sizes
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Control state
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic [63:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  // Captured request fields
  logic          write_q, write_d;
  logic [63:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [63:0]   wdata_q, wdata_d;

  // Storage array (contents survive reset)
  logic [63:0]   mem_q [DEPTH];

  // Decode of the captured request
  logic [2:0]    lane;
  logic [AW-1:0] word_idx;
  logic          out_of_range;
  logic          misaligned;
  logic          acc_err;
  logic [63:0]   rd_word;
  logic [63:0]   merged_word;
  logic [63:0]   load_data;

  // Commit strobe and array write enable
  logic          commit;
  logic          mem_we;

  // Byte-enable mask for an access of the given size, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Replace the addressed bytes of old_word with the low bytes of wdata.
  function automatic logic [63:0] merge_store(input logic [63:0] old_word,
                                              input logic [63:0] wdata,
                                              input logic [2:0]  lane_i,
                                              input logic [1:0]  size);
    logic [7:0]  be;
    logic [63:0] shw;
    logic [63:0] res;
    be  = size_mask(size) << lane_i;
    shw = wdata << {lane_i, 3'b000};
    res = old_word;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = shw[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // Pull the addressed field down to bit 0 and extend it to 64 bits.
  function automatic logic [63:0] extract_load(input logic [63:0] word,
                                               input logic [2:0]  lane_i,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [63:0] sh;
    logic [63:0] res;
    sh = word >> {lane_i, 3'b000};
    case (size)
      SZ_BYTE: res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      SZ_HALF: res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_WORD: res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Alignment check: the lane must be a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] lane_i,
                                         input logic [1:0] size);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = lane_i[0];
      SZ_WORD: r = |lane_i[1:0];
      default: r = |lane_i;
    endcase
    return r;
  endfunction

  // Decode the held request and precompute both the merged store word and the
  // extracted load value from the currently addressed array word.
  always_comb begin
    lane         = addr_q[2:0];
    word_idx     = addr_q[3+AW-1:3];
    out_of_range = |addr_q[63:3+AW];
    misaligned   = is_misaligned(lane, size_q);
    acc_err      = out_of_range | misaligned;
    rd_word      = mem_q[word_idx];
    merged_word  = merge_store(rd_word, wdata_q, lane, size_q);
    load_data    = extract_load(rd_word, lane, size_q, uns_q);
  end

  // Next-state logic: capture in IDLE, count down in WAIT, pulse in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    commit       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          // Store commit and response register share this edge.
          commit       = 1'b1;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = acc_err;
          resp_rdata_d = (acc_err || write_q) ? 64'd0 : load_data;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Array write only for a successful store; reset on the commit edge wins.
  always_comb begin
    mem_we = commit & write_q & ~acc_err & ~Reset;
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request holding registers; only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    wdata_q <= wdata_d;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= merged_word;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
